// File: rtl/hazard_stall_gen_if.sv
// D-stage decode view shared between the decoder and the hazard/stall generator.
// The decoder side drives the D fields and flush; the stall generator returns stall and md_busy.
interface hazard_stall_gen_if;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic [4:0] d_wreg;
  logic [1:0] d_tnew;
  logic       d_md_start;
  logic       d_md_div;
  logic       d_md_use;
  logic       flush;
  logic       stall;
  logic       md_busy;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wreg, d_tnew,
    output d_md_start, d_md_div, d_md_use, flush,
    input  stall, md_busy
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wreg, d_tnew,
    input  d_md_start, d_md_div, d_md_use, flush,
    output stall, md_busy
  );
endinterface

// File: rtl/hazard_stall_gen.sv
// Tuse/Tnew hazard detector for the 5-stage MIPS pipeline: tracks E/M destinations
// and the mult/div busy window, and requests a stall when forwarding cannot help.
module hazard_stall_gen #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_stall_gen_if.slave hz
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [4:0]       e_wreg_q, e_wreg_d;
  logic [1:0]       e_tnew_q, e_tnew_d;
  logic             e_md_q,   e_md_d;
  logic             e_div_q,  e_div_d;
  logic [4:0]       m_wreg_q, m_wreg_d;
  logic [1:0]       m_tnew_q, m_tnew_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic md_busy_w;
  logic stall_w;

  // A source with tuse=3 can never be below a 2-bit Tnew, so "not read" needs no special case.
  function automatic logic hz_chk(input logic [4:0] r, input logic [1:0] tu,
                                  input logic [4:0] w, input logic [1:0] tn);
    return (r != 5'd0) && (r == w) && (tu < tn);
  endfunction

  always_comb begin
    md_busy_w = e_md_q | (md_cnt_q != '0);
    stall_w   = !hz.flush &&
                ( hz_chk(hz.d_rs, hz.d_tuse_rs, e_wreg_q, e_tnew_q)
                | hz_chk(hz.d_rt, hz.d_tuse_rt, e_wreg_q, e_tnew_q)
                | hz_chk(hz.d_rs, hz.d_tuse_rs, m_wreg_q, m_tnew_q)
                | hz_chk(hz.d_rt, hz.d_tuse_rt, m_wreg_q, m_tnew_q)
                | (hz.d_md_use & md_busy_w) );
  end

  assign hz.md_busy = md_busy_w;
  assign hz.stall   = stall_w;

  always_comb begin
    e_wreg_d = '0;
    e_tnew_d = '0;
    e_md_d   = 1'b0;
    e_div_d  = 1'b0;
    m_wreg_d = '0;
    m_tnew_d = '0;
    md_cnt_d = md_cnt_q;

    if (!hz.flush) begin
      m_wreg_d = e_wreg_q;
      m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
      if (!stall_w) begin
        e_wreg_d = hz.d_wreg;
        e_tnew_d = hz.d_tnew;
        e_md_d   = hz.d_md_start;
        e_div_d  = hz.d_md_div;
      end
    end

    // The busy window keeps running through a flush; only an op flushed in E never starts it.
    if (e_md_q && !hz.flush) begin
      md_cnt_d = e_div_q ? DIV_LD : MULT_LD;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_wreg_q <= '0;
      e_tnew_q <= '0;
      e_md_q   <= 1'b0;
      e_div_q  <= 1'b0;
      m_wreg_q <= '0;
      m_tnew_q <= '0;
      md_cnt_q <= '0;
    end else begin
      e_wreg_q <= e_wreg_d;
      e_tnew_q <= e_tnew_d;
      e_md_q   <= e_md_d;
      e_div_q  <= e_div_d;
      m_wreg_q <= m_wreg_d;
      m_tnew_q <= m_tnew_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_gen.sv
// Bench for hazard_stall_gen: directed pipeline scenarios plus random decode traffic,
// checked every cycle against a ready-time model of in-flight producers.
module tb_hazard_stall_gen;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic rst_n;
  hazard_stall_gen_if bus ();

  hazard_stall_gen #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each cycle c records what entered E during c. A producer born in E at cycle b
  // with Tnew t has its result forwardable from cycle b+t; a consumer in D at cycle c
  // needs it by cycle c+tuse. Only producers still in E (b=c) or M (b=c-1) are visible.
  logic [4:0] tl_w   [0:7];
  int         tl_t   [0:7];
  bit         tl_md  [0:7];
  bit         tl_div [0:7];
  bit         killed [0:7];
  int         busy_end = -1;
  int         cyc = 0;

  initial begin
    for (int i = 0; i < 8; i++) begin
      tl_w[i] = '0; tl_t[i] = 0; tl_md[i] = 1'b0; tl_div[i] = 1'b0; killed[i] = 1'b0;
    end
  end

  function automatic bit late(input logic [4:0] r, input int tu, input logic [4:0] w,
                              input int tn, input int born, input int now);
    return (r != 5'd0) && (r == w) && (tu != 3) && (born + tn > now + tu);
  endfunction

  int   ce, cm, nx, m_t;
  logic [4:0] m_w;
  bit   hzd, exp_s, exp_b;

  always @(negedge clk) begin
    ce = cyc & 7;
    cm = (cyc - 1) & 7;
    nx = (cyc + 1) & 7;
    if (!rst_n) begin
      chk("rst_stall", {31'd0, bus.stall}, 32'd0);
      chk("rst_md_busy", {31'd0, bus.md_busy}, 32'd0);
      tl_w[ce] = '0; tl_t[ce] = 0; tl_md[ce] = 1'b0; tl_div[ce] = 1'b0; killed[ce] = 1'b0;
      tl_w[nx] = '0; tl_t[nx] = 0; tl_md[nx] = 1'b0; tl_div[nx] = 1'b0;
      busy_end = -1;
    end else begin
      m_w = killed[cm] ? 5'd0 : tl_w[cm];
      m_t = killed[cm] ? 0 : tl_t[cm];
      hzd = late(bus.d_rs, int'(bus.d_tuse_rs), tl_w[ce], tl_t[ce], cyc, cyc)
          | late(bus.d_rt, int'(bus.d_tuse_rt), tl_w[ce], tl_t[ce], cyc, cyc)
          | late(bus.d_rs, int'(bus.d_tuse_rs), m_w, m_t, cyc - 1, cyc)
          | late(bus.d_rt, int'(bus.d_tuse_rt), m_w, m_t, cyc - 1, cyc);
      exp_b = tl_md[ce] || (cyc <= busy_end);
      exp_s = !bus.flush && (hzd || (bus.d_md_use && exp_b));
      chk("stall", {31'd0, bus.stall}, {31'd0, exp_s});
      chk("md_busy", {31'd0, bus.md_busy}, {31'd0, exp_b});
      if (tl_md[ce] && !bus.flush) busy_end = cyc + (tl_div[ce] ? DIV_N : MULT_N);
      killed[ce] = bus.flush;
      if (bus.flush || exp_s) begin
        tl_w[nx] = '0; tl_t[nx] = 0; tl_md[nx] = 1'b0; tl_div[nx] = 1'b0;
      end else begin
        tl_w[nx] = bus.d_wreg; tl_t[nx] = int'(bus.d_tnew);
        tl_md[nx] = bus.d_md_start; tl_div[nx] = bus.d_md_div;
      end
    end
    cyc++;
  end

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tur,
                       input logic [1:0] tut, input logic [4:0] w, input logic [1:0] tn,
                       input logic ms, input logic md, input logic mu);
    bus.d_rs = rs; bus.d_rt = rt; bus.d_tuse_rs = tur; bus.d_tuse_rt = tut;
    bus.d_wreg = w; bus.d_tnew = tn; bus.d_md_start = ms; bus.d_md_div = md; bus.d_md_use = mu;
  endtask

  // Presents one D instruction and holds it until accepted; returns the stall cycles seen.
  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tur,
                       input logic [1:0] tut, input logic [4:0] w, input logic [1:0] tn,
                       input logic ms, input logic md, input logic mu, output int ns);
    @(posedge clk); #1;
    set_d(rs, rt, tur, tut, w, tn, ms, md, mu);
    bus.flush = 1'b0;
    #1;
    ns = 0;
    while (bus.stall === 1'b1 && ns < 40) begin
      ns++;
      @(posedge clk); #2;
    end
    if (ns >= 40) chk("stall_timeout", ns, 0);
  endtask

  int ns;

  initial begin
    rst_n = 1'b0;
    set_d(0, 0, 3, 3, 0, 0, 0, 0, 0);
    bus.flush = 1'b0;
    #1;
    chk("reset_stall", {31'd0, bus.stall}, 32'd0);
    chk("reset_md_busy", {31'd0, bus.md_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Load-use, then ALU->branch and load->branch.
    issue(0, 0, 3, 3, 8, 2, 0, 0, 0, ns);   chk("lw_issue", ns, 0);
    issue(8, 0, 1, 3, 11, 1, 0, 0, 0, ns);  chk("load_use", ns, 1);
    issue(0, 0, 3, 3, 9, 1, 0, 0, 0, ns);   chk("addu_issue", ns, 0);
    issue(9, 0, 0, 3, 0, 0, 0, 0, 0, ns);   chk("alu_branch", ns, 1);
    issue(0, 0, 3, 3, 10, 2, 0, 0, 0, ns);  chk("lw10_issue", ns, 0);
    issue(0, 10, 3, 0, 0, 0, 0, 0, 0, ns);  chk("load_branch", ns, 2);

    // $0 destination and unused sources.
    issue(0, 0, 3, 3, 0, 2, 0, 0, 0, ns);   chk("lw_r0", ns, 0);
    issue(0, 0, 1, 1, 12, 1, 0, 0, 0, ns);  chk("read_r0", ns, 0);
    issue(0, 0, 3, 3, 8, 2, 0, 0, 0, ns);   chk("lw8_again", ns, 0);
    issue(8, 0, 3, 3, 13, 1, 0, 0, 0, ns);  chk("tuse3", ns, 0);

    // MDU busy windows.
    issue(0, 0, 3, 3, 0, 0, 1, 0, 1, ns);   chk("mult_issue", ns, 0);
    issue(0, 0, 3, 3, 14, 2, 0, 0, 1, ns);  chk("mflo_after_mult", ns, 1 + MULT_N);
    chk("mult_busy_fall", {31'd0, bus.md_busy}, 32'd0);
    issue(0, 0, 3, 3, 0, 0, 1, 1, 1, ns);   chk("div_issue", ns, 0);
    issue(0, 0, 3, 3, 15, 2, 0, 0, 1, ns);  chk("mflo_after_div", ns, 1 + DIV_N);
    chk("div_busy_fall", {31'd0, bus.md_busy}, 32'd0);

    // Flush over a load-use pair, then a mult flushed while in E.
    issue(0, 0, 3, 3, 8, 2, 0, 0, 0, ns);
    @(posedge clk); #1;
    set_d(8, 0, 1, 3, 16, 1, 0, 0, 0); bus.flush = 1'b1;
    #1 chk("flush_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1 bus.flush = 1'b0;
    #1 chk("post_flush_stall", {31'd0, bus.stall}, 32'd0);
    issue(0, 0, 3, 3, 0, 0, 1, 0, 1, ns);
    @(posedge clk); #1;
    set_d(0, 0, 3, 3, 0, 0, 0, 0, 0); bus.flush = 1'b1;
    @(posedge clk); #1;
    set_d(0, 0, 3, 3, 17, 2, 0, 0, 1); bus.flush = 1'b0;
    #1 chk("flushed_mult_stall", {31'd0, bus.stall}, 32'd0);
    chk("flushed_mult_busy", {31'd0, bus.md_busy}, 32'd0);

    // Asynchronous reset in the middle of an MDU stall.
    issue(0, 0, 3, 3, 0, 0, 1, 0, 1, ns);
    @(posedge clk); #1;
    set_d(0, 0, 3, 3, 18, 2, 0, 0, 1);
    #1 chk("pre_reset_stall", {31'd0, bus.stall}, 32'd1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk("async_rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("async_rst_md_busy", {31'd0, bus.md_busy}, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    issue(0, 0, 3, 3, 18, 2, 0, 0, 1, ns);  chk("mflo_after_reset", ns, 0);

    // Random decode traffic over a small register set to provoke frequent matches.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      bus.d_rs       = 5'($urandom_range(0, 3));
      bus.d_rt       = 5'($urandom_range(0, 3));
      bus.d_tuse_rs  = 2'($urandom_range(0, 3));
      bus.d_tuse_rt  = 2'($urandom_range(0, 3));
      bus.d_wreg     = 5'($urandom_range(0, 3));
      bus.d_tnew     = 2'($urandom_range(0, 2));
      bus.d_md_start = ($urandom_range(0, 7) == 0);
      bus.d_md_div   = 1'($urandom_range(0, 1));
      bus.d_md_use   = bus.d_md_start | ($urandom_range(0, 3) == 0);
      bus.flush      = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk); #1;
    set_d(0, 0, 3, 3, 0, 0, 0, 0, 0); bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hazard_stall_gen.md
Name: hazard_stall_gen

Overview:
- Producer of the pipeline `stall` request consumed by the stall controller. That controller freezes PC and the D register and clears the E register.
- Tracks destination register and Tnew for the instructions in the E and M stages, plus the busy window of the multi-cycle mult/div unit (MDU).
- Compares these against the Tuse of the instruction currently in D and raises `stall` when forwarding cannot satisfy it.
- Sits beside the D-stage decoder in the 5-stage MIPS pipeline with exception flush.

Parameters:
- MULT_CYCLES, 5, extra busy cycles after a mult/multu leaves E.
- DIV_CYCLES, 10, extra busy cycles after a div/divu leaves E.
- CNT_W, 4, width of the MDU busy counter; must hold DIV_CYCLES.

Ports:
- clk  in  1  pipeline clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- d_rs  in  5  rs field of the D instruction.
- d_rt  in  5  rt field of the D instruction.
- d_tuse_rs  in  2  cycles until D needs rs: 0/1/2; 3 = rs not read.
- d_tuse_rt  in  2  same encoding, for rt.
- d_wreg  in  5  destination register of the D instruction; 0 = no write.
- d_tnew  in  2  Tnew the D instruction will have in E: ALU=1, load/mfhi/mflo=2 per the decoder table, 0 = result ready.
- d_md_start  in  1  D holds mult/multu/div/divu.
- d_md_div  in  1  with d_md_start: 1 = div, 0 = mult.
- d_md_use  in  1  D holds any MDU instruction: mult/div/mfhi/mflo/mthi/mtlo.
- flush  in  1  exception/eret flush of the D, E and M stages this cycle.
- stall  out  1  to the stall controller.
- md_busy  out  1  MDU busy, for debug and the exception unit.

Behaviour:
- State:
  - E slot {e_wreg[4:0], e_tnew[1:0], e_md, e_div}.
  - M slot {m_wreg[4:0], m_tnew[1:0]}.
  - MDU counter md_cnt[CNT_W-1:0].
- Async reset (rst_n=0): all slots and md_cnt = 0. Then stall=0 and md_busy=0 immediately, without waiting for a clock.
- Combinational outputs:
  - md_busy = e_md | (md_cnt != 0).
  - hz_E(r,tu) = (r != 0) & (r == e_wreg) & (tu < e_tnew).
  - hz_M(r,tu) = (r != 0) & (r == m_wreg) & (tu < m_tnew).
  - A source with tuse=3 never hazards. W stage never hazards: Tnew is 0 there.
  - stall = !flush & ( hz_E(d_rs,d_tuse_rs) | hz_E(d_rt,d_tuse_rt) | hz_M(d_rs,d_tuse_rs) | hz_M(d_rt,d_tuse_rt) | (d_md_use & md_busy) ).
- Per rising edge, in priority order:
  - flush=1: E slot and M slot cleared to bubble (all zero). md_cnt continues normally. An MDU op already past E is not aborted; an e_md instruction being flushed does not start the counter.
  - Otherwise M slot: m_wreg <= e_wreg; m_tnew <= (e_tnew==0) ? 0 : e_tnew-1.
  - Otherwise E slot: stall=1 loads a bubble (matches the E clear); stall=0 loads {d_wreg, d_tnew, d_md_start, d_md_div}.
  - md_cnt: if e_md & !flush, load DIV_CYCLES or MULT_CYCLES per e_div. Else if md_cnt != 0, decrement. Otherwise hold 0.
- Total busy window for one mult = 1 cycle (in E) + MULT_CYCLES; a dependent MDU instruction in D stalls for exactly that many cycles.
- e_md while md_cnt != 0 cannot occur, because the issuing instruction was stalled in D. No priority case is needed beyond the load-wins rule above.
- Register $0 destination never causes a stall, whatever Tnew it carries.
- Reset mid-stall: stall drops asynchronously with rst_n; the counter is lost.

Test Plan:
1. Load-use: cycle n D=lw $8 (d_wreg=8, d_tnew=2); n+1 D=add reading $8 (tuse_rs=1):
   - stall=1 at n+1, because the E-slot tnew of 2 exceeds tuse 1.
   - stall=0 at n+2, when the lw sits in M with m_tnew=1 and tuse 1 is satisfied.
   - Exactly one bubble enters E.
2. Branch after ALU: D=addu $9 (tnew 1), then beq reading $9 (tuse 0):
   - stall one cycle with E hazard, one cycle with M hazard (m_tnew=0 → none).
   - Expect stall=1 for exactly 1 cycle; then a lw→beq pair stalls 2 cycles.
3. $0 and unused sources: D=lw $0 followed by an add reading $0, then an instruction with tuse_rs=3 and rs=8 behind lw $8 → stall stays 0 in both cases.
4. MDU: mult issued (d_md_start=1, div=0), followed by mflo (d_md_use=1):
   - stall=1 for 1+5=6 consecutive cycles; md_busy falls together with stall.
   - Repeat with div → 11 cycles.
5. Flush: lw $8 in E, add $8 in D, assert flush for one cycle:
   - stall=0 that cycle; next cycle E and M are bubbles and stall=0.
   - A mult flushed while in E leaves md_cnt=0.
6. Async reset: during stall from scenario 4, drop rst_n between clock edges → stall and md_busy go 0 immediately; after release, a new mflo has no stall.
